// File: rtl/alu_result_demux.sv
// Registered 1:N write-back demux: routes one ALU result into one of NUM_DEST
// holding slots, with valid/ready back-pressure while the addressed slot is full.
module alu_result_demux #(
  parameter int WIDTH    = 32,
  parameter int NUM_DEST = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  output logic [NUM_DEST-1:0]       out_valid,
  output logic [NUM_DEST*WIDTH-1:0] out_data,
  input  logic [NUM_DEST-1:0]       out_ack,
  output logic [7:0]                err_cnt
);

  logic [NUM_DEST-1:0]       valid_q, valid_d;
  logic [NUM_DEST*WIDTH-1:0] data_q, data_d;
  logic [7:0]                err_q, err_d;
  logic [NUM_DEST-1:0]       sel_hit;
  logic                      legal;
  logic                      slot_free;
  logic                      accept;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // One-hot decode avoids indexing past NUM_DEST when the select is out of range.
  always_comb begin
    sel_hit = '0;
    for (int i = 0; i < NUM_DEST; i++) begin
      sel_hit[i] = (in_sel == SEL_W'(i));
    end
  end

  assign legal     = |sel_hit;
  assign slot_free = |(sel_hit & (~valid_q | out_ack));
  assign in_ready  = ~legal | slot_free;
  assign accept    = in_valid & in_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    for (int i = 0; i < NUM_DEST; i++) begin
      if (out_ack[i]) begin
        valid_d[i] = 1'b0;
      end
      // An accept on the same edge as an ack wins, so the slot stays full.
      if (accept && sel_hit[i]) begin
        valid_d[i]                = 1'b1;
        data_d[i*WIDTH +: WIDTH]  = in_data;
      end
    end
    if (accept && !legal) begin
      err_d = sat_inc8(err_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      err_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_alu_result_demux.sv
// Directed bench for alu_result_demux: a 4-slot instance for the main behaviour
// and a 3-slot instance for the bad-select error counter.
module tb_alu_result_demux;

  logic         clk = 1'b0;
  logic         rst_n;

  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [1:0]   in_sel;
  logic [3:0]   out_valid;
  logic [127:0] out_data;
  logic [3:0]   out_ack;
  logic [7:0]   err_cnt;

  logic         in_valid3;
  logic         in_ready3;
  logic [31:0]  in_data3;
  logic [1:0]   in_sel3;
  logic [2:0]   out_valid3;
  logic [95:0]  out_data3;
  logic [2:0]   out_ack3;
  logic [7:0]   err_cnt3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_result_demux #(.WIDTH(32), .NUM_DEST(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_data(out_data), .out_ack(out_ack), .err_cnt(err_cnt)
  );

  alu_result_demux #(.WIDTH(32), .NUM_DEST(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .in_sel(in_sel3),
    .out_valid(out_valid3), .out_data(out_data3), .out_ack(out_ack3), .err_cnt(err_cnt3)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write1(input logic [1:0] sel, input logic [31:0] data);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAAAA_AAAA;
    in_sel    = 2'd0;
    out_ack   = 4'b0000;
    in_valid3 = 1'b1;
    in_data3  = 32'h5555_5555;
    in_sel3   = 2'd3;
    out_ack3  = 3'b000;

    // T1: reset held two cycles with traffic present
    tick();
    tick();
    chk("t1_valid", 128'(out_valid), 128'h0);
    chk("t1_data",  out_data, 128'h0);
    chk("t1_err",   128'(err_cnt), 128'h0);
    chk("t1_err3",  128'(err_cnt3), 128'h0);
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_valid3 = 1'b0;
    tick();

    // T2: basic write to slot 2
    in_valid = 1'b1;
    in_sel   = 2'd2;
    in_data  = 32'hDEAD_BEEF;
    #1;
    chk("t2_ready", 128'(in_ready), 128'h1);
    tick();
    in_valid = 1'b0;
    chk("t2_valid", 128'(out_valid), 128'h4);
    chk("t2_slot2", 128'(out_data[64 +: 32]), 128'hDEAD_BEEF);
    chk("t2_slot0", 128'(out_data[0 +: 32]), 128'h0);

    // T3: back-pressure on full slot 1, then ack and accept on the same edge
    write1(2'd1, 32'h1111_1111);
    chk("t3_fill", 128'(out_valid), 128'h6);
    in_valid = 1'b1;
    in_sel   = 2'd1;
    in_data  = 32'h2222_2222;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_stall_ready", 128'(in_ready), 128'h0);
      tick();
      chk("t3_stall_data", 128'(out_data[32 +: 32]), 128'h1111_1111);
    end
    out_ack = 4'b0010;
    #1;
    chk("t3_ack_ready", 128'(in_ready), 128'h1);
    tick();
    out_ack  = 4'b0000;
    in_valid = 1'b0;
    chk("t3_new_data", 128'(out_data[32 +: 32]), 128'h2222_2222);
    chk("t3_valid", 128'(out_valid), 128'h6);

    // T4: ack-only on slot 0 keeps the data word
    write1(2'd0, 32'h0C0C_0C0C);
    chk("t4_fill", 128'(out_valid), 128'h7);
    out_ack = 4'b0001;
    tick();
    out_ack = 4'b0000;
    chk("t4_valid", 128'(out_valid), 128'h6);
    chk("t4_data", 128'(out_data[0 +: 32]), 128'h0C0C_0C0C);

    // Multiple acks at once, then acks to empty slots
    out_ack = 4'b0110;
    tick();
    chk("multi_ack", 128'(out_valid), 128'h0);
    out_ack = 4'b1111;
    tick();
    out_ack = 4'b0000;
    chk("empty_ack_valid", 128'(out_valid), 128'h0);
    chk("empty_ack_data", out_data, {32'h0, 32'hDEAD_BEEF, 32'h2222_2222, 32'h0C0C_0C0C});

    // T5: bad select on the 3-slot instance, counter saturates
    in_valid3 = 1'b1;
    in_sel3   = 2'd3;
    in_data3  = 32'h7777_7777;
    for (int i = 0; i < 260; i++) begin
      #1;
      chk("t5_ready", 128'(in_ready3), 128'h1);
      tick();
      if (i == 9) chk("t5_err10", 128'(err_cnt3), 128'd10);
    end
    in_valid3 = 1'b0;
    chk("t5_err_sat", 128'(err_cnt3), 128'hFF);
    chk("t5_valid", 128'(out_valid3), 128'h0);
    chk("t5_data", 128'(out_data3), 128'h0);
    chk("t5_other_err", 128'(err_cnt), 128'h0);

    // Legal write on the 3-slot instance still works
    in_valid3 = 1'b1;
    in_sel3   = 2'd2;
    in_data3  = 32'h3333_3333;
    tick();
    in_valid3 = 1'b0;
    chk("t5_legal_valid", 128'(out_valid3), 128'h4);
    chk("t5_legal_err", 128'(err_cnt3), 128'hFF);

    // T6: reset on the same edge as an accept to slot 1
    write1(2'd0, 32'h0000_0001);
    write1(2'd3, 32'h0000_0003);
    chk("t6_fill", 128'(out_valid), 128'h9);
    in_valid = 1'b1;
    in_sel   = 2'd1;
    in_data  = 32'h5A5A_5A5A;
    rst_n    = 1'b0;
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    chk("t6_valid", 128'(out_valid), 128'h0);
    chk("t6_data", out_data, 128'h0);
    chk("t6_err3", 128'(err_cnt3), 128'h0);
    chk("t6_valid3", 128'(out_valid3), 128'h0);
    tick();
    chk("t6_slot1", 128'(out_data[32 +: 32]), 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
